// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
// Holds fetch FSM states, IF/ID bundle and fixed encodings.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // True when a byte address is misaligned or past the end of memory.
    function automatic logic addr_bad(
        input logic [31:0] a,
        input logic [32:0] limit
    );
        return (a[1:0] != 2'b00) || ({1'b0, a} >= limit);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, control inputs and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_instr,
        output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr,
        output halted, fault, fault_pc, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_instr,
        input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr,
        input  halted, fault, fault_pc, fetch_count
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with redirect/hold/increment mux.
// Also flags illegal current PC and illegal redirect target.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_bad,
    output logic        tgt_bad
);

    localparam logic [32:0] LIMIT = 33'(IMEM_DEPTH) << 2;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_bad   = addr_bad(pc_q, LIMIT);
    assign tgt_bad  = addr_bad(load_pc, LIMIT);

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register, BOOT/RUN/HALT/FAULT control.
// Instruction memory is combinational; data is captured same cycle.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_stage_if.master bus
);

    import riscv_pkg::*;

    localparam if_id_t BUBBLE = '{
        valid:    1'b0,
        pc:       32'h0,
        pc_plus4: 32'h0,
        instr:    NOP_INSTR
    };

    fetch_state_t state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  cnt_q, cnt_d;

    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         pc_bad;
    logic         tgt_bad;

    pc_reg #(
        .RESET_PC  (RESET_PC),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .inc     (pc_inc),
        .load_pc (bus.redirect_pc),
        .pc      (pc),
        .pc_plus4(pc_plus4),
        .pc_bad  (pc_bad),
        .tgt_bad (tgt_bad)
    );

    always_comb begin
        state_d    = state_q;
        if_id_d    = if_id_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.redirect_valid && tgt_bad) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = bus.redirect_pc;
                    if_id_d    = BUBBLE;
                end else if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                    if_id_d = BUBBLE;
                end else if (bus.stall) begin
                    if_id_d = if_id_q;
                end else if (pc_bad) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc;
                    if_id_d    = BUBBLE;
                end else begin
                    if_id_d = '{
                        valid:    1'b1,
                        pc:       pc,
                        pc_plus4: pc_plus4,
                        instr:    bus.imem_instr
                    };
                    pc_inc = 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                    if (bus.imem_instr == EBREAK_INSTR) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            // A stalled decode still owns the EBREAK until it is consumed.
            HALT: begin
                if (!bus.stall) begin
                    if_id_d = BUBBLE;
                end
            end
            FAULT: begin
                if_id_d = BUBBLE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            if_id_q    <= BUBBLE;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
            cnt_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            if_id_q    <= if_id_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = if_id_q.valid;
    assign bus.id_pc       = if_id_q.pc;
    assign bus.id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.id_instr    = if_id_q.instr;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: full-depth and 4-word instances.
// Expected IF/ID state is queued per cycle and popped after the edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EB  = 32'h0010_0073;

    typedef struct {
        logic        v;
        bit          pcchk;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] cnt;
        logic        h;
        logic        f;
        logic [31:0] fpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1 = 1'b0;
    logic        rst2 = 1'b0;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] mem [256];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage_if bus1 ();
    fetch_stage_if bus2 ();

    assign bus1.stall          = stall;
    assign bus1.redirect_valid = rv;
    assign bus1.redirect_pc    = rpc;
    assign bus1.imem_instr     = mem[bus1.imem_addr[9:2]];
    assign bus2.stall          = 1'b0;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    assign bus2.imem_instr     = mem[bus2.imem_addr[9:2]];

    fetch_stage #(.IMEM_DEPTH(256)) dut1 (
        .clk  (clk),
        .rst_n(rst1),
        .bus  (bus1)
    );

    fetch_stage #(.IMEM_DEPTH(4)) dut2 (
        .clk  (clk),
        .rst_n(rst2),
        .bus  (bus2)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t bub(
        input logic [31:0] addr,
        input logic [31:0] cnt,
        input logic        h,
        input logic        f,
        input logic [31:0] fpc
    );
        exp_t e;
        e = '{v: 1'b0, pcchk: 1'b0, pc: 32'h0, p4: 32'h0,
              instr: NOP, addr: addr, cnt: cnt,
              h: h, f: f, fpc: fpc};
        return e;
    endfunction

    function automatic exp_t iss(
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic [31:0] addr,
        input logic [31:0] cnt,
        input logic        h
    );
        exp_t e;
        e = '{v: 1'b1, pcchk: 1'b1, pc: pc, p4: pc + 32'd4,
              instr: instr, addr: addr, cnt: cnt,
              h: h, f: 1'b0, fpc: 32'h0};
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e = bub(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        e.pcchk = 1'b1;
        return e;
    endfunction

    task automatic cyc(input string tag, input exp_t e, input bit d2);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (d2) begin
            chk({tag, ".valid"}, 32'(bus2.id_valid), 32'(x.v));
            chk({tag, ".instr"}, bus2.id_instr, x.instr);
            chk({tag, ".addr"}, bus2.imem_addr, x.addr);
            chk({tag, ".cnt"}, bus2.fetch_count, x.cnt);
            chk({tag, ".halt"}, 32'(bus2.halted), 32'(x.h));
            chk({tag, ".fault"}, 32'(bus2.fault), 32'(x.f));
            chk({tag, ".fpc"}, bus2.fault_pc, x.fpc);
            if (x.pcchk) begin
                chk({tag, ".pc"}, bus2.id_pc, x.pc);
                chk({tag, ".pc4"}, bus2.id_pc_plus4, x.p4);
            end
        end else begin
            chk({tag, ".valid"}, 32'(bus1.id_valid), 32'(x.v));
            chk({tag, ".instr"}, bus1.id_instr, x.instr);
            chk({tag, ".addr"}, bus1.imem_addr, x.addr);
            chk({tag, ".cnt"}, bus1.fetch_count, x.cnt);
            chk({tag, ".halt"}, 32'(bus1.halted), 32'(x.h));
            chk({tag, ".fault"}, 32'(bus1.fault), 32'(x.f));
            chk({tag, ".fpc"}, bus1.fault_pc, x.fpc);
            if (x.pcchk) begin
                chk({tag, ".pc"}, bus1.id_pc, x.pc);
                chk({tag, ".pc4"}, bus1.id_pc_plus4, x.p4);
            end
        end
    endtask

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = w(i);
        end
        mem[4] = EB;

        // reset and free run
        cyc("rst0", rst_exp(), 1'b0);
        cyc("rst1", rst_exp(), 1'b0);
        rst1 = 1'b1;
        cyc("boot", bub(32'h0, 32'd0, 1'b0, 1'b0, 32'h0), 1'b0);
        cyc("run0", iss(32'h00, w(0), 32'h04, 32'd1, 1'b0), 1'b0);
        cyc("run4", iss(32'h04, w(1), 32'h08, 32'd2, 1'b0), 1'b0);
        cyc("run8", iss(32'h08, w(2), 32'h0C, 32'd3, 1'b0), 1'b0);

        // stall hold
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("stall", iss(32'h08, w(2), 32'h0C, 32'd3, 1'b0), 1'b0);
        end
        stall = 1'b0;
        cyc("runC", iss(32'h0C, w(3), 32'h10, 32'd4, 1'b0), 1'b0);

        // redirect beats stall
        stall = 1'b1;
        rv    = 1'b1;
        rpc   = 32'h40;
        cyc("redir", bub(32'h40, 32'd4, 1'b0, 1'b0, 32'h0), 1'b0);
        stall = 1'b0;
        rv    = 1'b0;
        cyc("run40", iss(32'h40, w(16), 32'h44, 32'd5, 1'b0), 1'b0);

        // misaligned redirect faults and sticks
        rv  = 1'b1;
        rpc = 32'h42;
        cyc("mis", bub(32'h44, 32'd5, 1'b0, 1'b1, 32'h42), 1'b0);
        rpc = 32'h0;
        cyc("stky", bub(32'h44, 32'd5, 1'b0, 1'b1, 32'h42), 1'b0);
        rv = 1'b0;
        cyc("stky2", bub(32'h44, 32'd5, 1'b0, 1'b1, 32'h42), 1'b0);

        // out-of-range redirect after reset
        rst1 = 1'b0;
        cyc("rst2", rst_exp(), 1'b0);
        rst1 = 1'b1;
        cyc("boot2", bub(32'h0, 32'd0, 1'b0, 1'b0, 32'h0), 1'b0);
        rv  = 1'b1;
        rpc = 32'h400;
        cyc("oor", bub(32'h0, 32'd0, 1'b0, 1'b1, 32'h400), 1'b0);
        rv = 1'b0;

        // EBREAK halt
        rst1 = 1'b0;
        cyc("rst3", rst_exp(), 1'b0);
        rst1 = 1'b1;
        cyc("boot3", bub(32'h0, 32'd0, 1'b0, 1'b0, 32'h0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("pre", iss(32'(4 * i), w(i), 32'(4 * i + 4),
                32'(i + 1), 1'b0), 1'b0);
        end
        cyc("ebrk", iss(32'h10, EB, 32'h14, 32'd5, 1'b1), 1'b0);
        cyc("halt", bub(32'h14, 32'd5, 1'b1, 1'b0, 32'h0), 1'b0);
        rv  = 1'b1;
        rpc = 32'h0;
        cyc("hign", bub(32'h14, 32'd5, 1'b1, 1'b0, 32'h0), 1'b0);
        rv = 1'b0;

        // 4-word memory runs off the end
        cyc("d2rst", rst_exp(), 1'b1);
        rst2 = 1'b1;
        cyc("d2boot", bub(32'h0, 32'd0, 1'b0, 1'b0, 32'h0), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc("d2run", iss(32'(4 * i), w(i), 32'(4 * i + 4),
                32'(i + 1), 1'b0), 1'b1);
        end
        cyc("d2end", bub(32'h10, 32'd4, 1'b0, 1'b1, 32'h10), 1'b1);
        cyc("d2stk", bub(32'h10, 32'd4, 1'b0, 1'b1, 32'h10), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
